// File: rtl/regfile_port_arbiter.sv
// Register file port arbiter: shares the single register file access slot
// between decode-stage reads and buffered write-back writes. Reads never
// overtake a buffered write to the same register, and a hazard-free read
// waits for at most MAX_WR_BURST consecutive write grants.
module regfile_port_arbiter #(
  parameter int WBUF_DEPTH   = 2,
  parameter int MAX_WR_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_req_valid,
  output logic                          rd_req_ready,
  input  logic [4:0]                    rd_rs,
  input  logic [4:0]                    rd_rt,
  output logic                          rd_rsp_valid,
  input  logic                          wr_req_valid,
  output logic                          wr_req_ready,
  input  logic [4:0]                    wr_addr,
  input  logic [31:0]                   wr_data,
  output logic                          rf_regwrite,
  output logic [4:0]                    rf_rs,
  output logic [4:0]                    rf_rt,
  output logic [4:0]                    rf_rd,
  output logic [31:0]                   rf_writedata,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_WR_BURST + 1);
  localparam logic [CW-1:0] DepthC = CW'(WBUF_DEPTH);
  localparam logic [SW-1:0] BurstC = SW'(MAX_WR_BURST);

  logic [4:0]            addrMem_q [WBUF_DEPTH];
  logic [31:0]           dataMem_q [WBUF_DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  rspValid_q, rspValid_d;

  logic [WBUF_DEPTH-1:0] slotUsed;
  logic                  hazard;
  logic                  push;
  logic                  pop;
  logic                  grantWrite;
  logic                  grantRead;

  // A read is hazarded when any occupied buffer slot targets rs or rt;
  // register 0 is never buffered, but is excluded explicitly for clarity.
  always_comb begin
    slotUsed = '0;
    hazard   = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      slotUsed[i] = ({1'b0, PW'(i) - head_q} < count_q);
      if (slotUsed[i] && (addrMem_q[i] != 5'd0) &&
          ((addrMem_q[i] == rd_rs) || (addrMem_q[i] == rd_rt))) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && rd_req_valid;
  end

  // Slot arbitration: writes win unless a hazard-free read has already
  // waited through a full write burst; nothing is granted during reset.
  always_comb begin
    wr_req_ready = !rst && (count_q < DepthC);
    push         = wr_req_valid && wr_req_ready && (wr_addr != 5'd0);
    grantWrite   = !rst && (count_q != '0) &&
                   (!rd_req_valid || hazard || (streak_q < BurstC));
    grantRead    = !rst && !grantWrite && rd_req_valid;
    pop          = grantWrite;
  end

  // Next-state values for the FIFO pointers, occupancy and write streak.
  always_comb begin
    head_d     = pop  ? head_q + PW'(1) : head_q;
    tail_d     = push ? tail_q + PW'(1) : tail_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    streak_d   = '0;
    if (grantWrite && rd_req_valid) begin
      streak_d = (streak_q == BurstC) ? BurstC : streak_q + SW'(1);
    end
    rspValid_d = grantRead;
  end

  // Control state with synchronous reset; buffered writes are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      streak_q   <= '0;
      rspValid_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      streak_q   <= streak_d;
      rspValid_q <= rspValid_d;
    end
  end

  // Buffer storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem_q[tail_q] <= wr_addr;
      dataMem_q[tail_q] <= wr_data;
    end
  end

  // Register file drive: write fields are zero unless a write is granted.
  always_comb begin
    rd_req_ready = grantRead;
    rd_rsp_valid = rspValid_q;
    rf_regwrite  = grantWrite;
    rf_rs        = rd_rs;
    rf_rt        = rd_rt;
    rf_rd        = grantWrite ? addrMem_q[head_q] : 5'd0;
    rf_writedata = grantWrite ? dataMem_q[head_q] : 32'd0;
    wbuf_count   = count_q;
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Testbench for regfile_port_arbiter: directed vector table, hand-written
// reset sequence, then randomized traffic against a queue-based model.
module tb_regfile_port_arbiter;

  localparam int DEPTH = 2;
  localparam int MAXB  = 4;

  logic        clk;
  logic        rst;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [4:0]  rd_rs;
  logic [4:0]  rd_rt;
  logic        rd_rsp_valid;
  logic        wr_req_valid;
  logic        wr_req_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rf_regwrite;
  logic [4:0]  rf_rs;
  logic [4:0]  rf_rt;
  logic [4:0]  rf_rd;
  logic [31:0] rf_writedata;
  logic [$clog2(DEPTH):0] wbuf_count;

  regfile_port_arbiter #(.WBUF_DEPTH(DEPTH), .MAX_WR_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_rs(rd_rs), .rd_rt(rd_rt), .rd_rsp_valid(rd_rsp_valid),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rf_regwrite(rf_regwrite), .rf_rs(rf_rs), .rf_rt(rf_rt),
    .rf_rd(rf_rd), .rf_writedata(rf_writedata), .wbuf_count(wbuf_count)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with registered read outputs; reads only when not writing.
  logic [31:0] tbRegs [32];
  logic [31:0] rfA, rfB;
  initial for (int i = 0; i < 32; i++) tbRegs[i] = 32'd0;
  always @(posedge clk) begin
    if (rf_regwrite) begin
      if (rf_rd != 5'd0) tbRegs[rf_rd] <= rf_writedata;
    end else begin
      rfA <= (rf_rs == 5'd0) ? 32'd0 : tbRegs[rf_rs];
      rfB <= (rf_rt == 5'd0) ? 32'd0 : tbRegs[rf_rt];
    end
  end

  typedef struct {
    bit          rdv;
    logic [4:0]  rs;
    logic [4:0]  rt;
    bit          wrv;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          eRdRdy;
    bit          eWrRdy;
    bit          eRw;
    logic [4:0]  eRd;
    logic [31:0] eWd;
    int          eCnt;
    bit          eRsp;
    logic [31:0] eA;
    logic [31:0] eB;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  int errCount;
  int checkCount;

  bit         prevHold;
  logic [4:0] prevRs, prevRt;

  vec_t vecs [31];
  vec_t hand [6];
  vec_t idleVec;

  wr_t         mq [$];
  int          mStreak;
  bit          mRsp;
  logic [31:0] mRegs [32];
  bit          mKnown [32];
  logic [31:0] mExpA, mExpB;
  bit          mExpKnown;
  bit          pending;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rdv, input logic [4:0] rs, input logic [4:0] rt,
                               input bit wrv, input logic [4:0] wa, input logic [31:0] wd);
    rd_req_valid = rdv;
    rd_rs        = rs;
    rd_rt        = rt;
    wr_req_valid = wrv;
    wr_addr      = wa;
    wr_data      = wd;
  endtask

  // A read left waiting must be re-presented unchanged.
  task automatic holdCheck(input string tag);
    if (prevHold && !rst)
      checkOutput({tag, ".rd_hold"}, {21'd0, rd_req_valid, rd_rs, rd_rt},
                  {21'd0, 1'b1, prevRs, prevRt});
  endtask

  task automatic sampleHold();
    prevHold = rd_req_valid && !rd_req_ready && !rst;
    prevRs   = rd_rs;
    prevRt   = rd_rt;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v.rdv, v.rs, v.rt, v.wrv, v.wa, v.wd);
    holdCheck(tag);
    #1;
    checkOutput({tag, ".rd_req_ready"}, 32'(rd_req_ready), 32'(v.eRdRdy));
    checkOutput({tag, ".wr_req_ready"}, 32'(wr_req_ready), 32'(v.eWrRdy));
    checkOutput({tag, ".rf_regwrite"},  32'(rf_regwrite),  32'(v.eRw));
    checkOutput({tag, ".rf_rd"},        32'(rf_rd),        32'(v.eRd));
    checkOutput({tag, ".rf_writedata"}, rf_writedata,      v.eWd);
    checkOutput({tag, ".wbuf_count"},   32'(wbuf_count),   v.eCnt);
    checkOutput({tag, ".rd_rsp_valid"}, 32'(rd_rsp_valid), 32'(v.eRsp));
    checkOutput({tag, ".rf_rs"},        32'(rf_rs),        32'(v.rs));
    checkOutput({tag, ".rf_rt"},        32'(rf_rt),        32'(v.rt));
    if (v.eRsp) begin
      checkOutput({tag, ".rdataA"}, rfA, v.eA);
      checkOutput({tag, ".rdataB"}, rfB, v.eB);
    end
    sampleHold();
    tick();
  endtask

  task automatic checkInReset(input string tag);
    checkOutput({tag, ".rd_req_ready"}, 32'(rd_req_ready), 32'd0);
    checkOutput({tag, ".wr_req_ready"}, 32'(wr_req_ready), 32'd0);
    checkOutput({tag, ".rf_regwrite"},  32'(rf_regwrite),  32'd0);
  endtask

  // Main sequence: reset, vector table, reset-with-traffic, random traffic.
  initial begin
    errCount   = 0;
    checkCount = 0;
    prevHold   = 1'b0;
    prevRs     = 5'd0;
    prevRt     = 5'd0;
    rst        = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);

    idleVec = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 0, 1'b0, 32'd0, 32'd0};

    //          rdv  rs     rt     wrv  wa      wd             rdRdy wrRdy rw   rd      wd             cnt rsp  A              B
    vecs[0]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    vecs[1]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1, 1'b0, 32'd0,        32'd0};
    vecs[2]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    vecs[3]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b1, 32'hDEADBEEF, 32'd0};
    vecs[4]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd7,  32'h7777,     1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    vecs[5]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 1'b1, 5'd7,  32'h7777,     1, 1'b0, 32'd0,        32'd0};
    vecs[6]  = '{1'b1, 5'd7, 5'd0, 1'b1, 5'd7,  32'h8888,     1'b1, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    vecs[7]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 1'b1, 5'd7,  32'h8888,     1, 1'b1, 32'h7777,     32'd0};
    vecs[8]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd0,  32'hBAD,      1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    vecs[9]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    vecs[10] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd3,  32'h33,       1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    vecs[11] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd4,  32'h44,       1'b0, 1'b1, 1'b1, 5'd3,  32'h33,       1, 1'b0, 32'd0,        32'd0};
    vecs[12] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 1'b1, 5'd4,  32'h44,       1, 1'b0, 32'd0,        32'd0};
    vecs[13] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd8,  32'h108,      1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    vecs[14] = '{1'b1, 5'd3, 5'd4, 1'b1, 5'd9,  32'h109,      1'b0, 1'b1, 1'b1, 5'd8,  32'h108,      1, 1'b0, 32'd0,        32'd0};
    vecs[15] = '{1'b1, 5'd3, 5'd4, 1'b1, 5'd10, 32'h10A,      1'b0, 1'b1, 1'b1, 5'd9,  32'h109,      1, 1'b0, 32'd0,        32'd0};
    vecs[16] = '{1'b1, 5'd3, 5'd4, 1'b1, 5'd11, 32'h10B,      1'b0, 1'b1, 1'b1, 5'd10, 32'h10A,      1, 1'b0, 32'd0,        32'd0};
    vecs[17] = '{1'b1, 5'd3, 5'd4, 1'b1, 5'd12, 32'h10C,      1'b0, 1'b1, 1'b1, 5'd11, 32'h10B,      1, 1'b0, 32'd0,        32'd0};
    vecs[18] = '{1'b1, 5'd3, 5'd4, 1'b1, 5'd13, 32'h10D,      1'b1, 1'b1, 1'b0, 5'd0,  32'd0,        1, 1'b0, 32'd0,        32'd0};
    vecs[19] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd14, 32'h10E,      1'b0, 1'b0, 1'b1, 5'd12, 32'h10C,      2, 1'b1, 32'h33,       32'h44};
    vecs[20] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd14, 32'h10E,      1'b0, 1'b1, 1'b1, 5'd13, 32'h10D,      1, 1'b0, 32'd0,        32'd0};
    vecs[21] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 1'b1, 5'd14, 32'h10E,      1, 1'b0, 32'd0,        32'd0};
    vecs[22] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd8,  32'h801,      1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    vecs[23] = '{1'b1, 5'd8, 5'd0, 1'b1, 5'd8,  32'h802,      1'b0, 1'b1, 1'b1, 5'd8,  32'h801,      1, 1'b0, 32'd0,        32'd0};
    vecs[24] = '{1'b1, 5'd8, 5'd0, 1'b1, 5'd8,  32'h803,      1'b0, 1'b1, 1'b1, 5'd8,  32'h802,      1, 1'b0, 32'd0,        32'd0};
    vecs[25] = '{1'b1, 5'd8, 5'd0, 1'b1, 5'd8,  32'h804,      1'b0, 1'b1, 1'b1, 5'd8,  32'h803,      1, 1'b0, 32'd0,        32'd0};
    vecs[26] = '{1'b1, 5'd8, 5'd0, 1'b1, 5'd8,  32'h805,      1'b0, 1'b1, 1'b1, 5'd8,  32'h804,      1, 1'b0, 32'd0,        32'd0};
    vecs[27] = '{1'b1, 5'd8, 5'd0, 1'b1, 5'd8,  32'h806,      1'b0, 1'b1, 1'b1, 5'd8,  32'h805,      1, 1'b0, 32'd0,        32'd0};
    vecs[28] = '{1'b1, 5'd8, 5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 1'b1, 5'd8,  32'h806,      1, 1'b0, 32'd0,        32'd0};
    vecs[29] = '{1'b1, 5'd8, 5'd0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    vecs[30] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b1, 32'h806,      32'd0};

    hand[0]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd20, 32'h2000,     1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        0, 1'b0, 32'd0,        32'd0};
    hand[1]  = '{1'b1, 5'd3, 5'd4, 1'b1, 5'd21, 32'h2001,     1'b0, 1'b1, 1'b1, 5'd20, 32'h2000,     1, 1'b0, 32'd0,        32'd0};
    hand[2]  = '{1'b1, 5'd3, 5'd4, 1'b1, 5'd22, 32'h2002,     1'b0, 1'b1, 1'b1, 5'd21, 32'h2001,     1, 1'b0, 32'd0,        32'd0};
    hand[3]  = '{1'b1, 5'd3, 5'd4, 1'b1, 5'd23, 32'h2003,     1'b0, 1'b1, 1'b1, 5'd22, 32'h2002,     1, 1'b0, 32'd0,        32'd0};
    hand[4]  = '{1'b1, 5'd3, 5'd4, 1'b1, 5'd24, 32'h2004,     1'b0, 1'b1, 1'b1, 5'd23, 32'h2003,     1, 1'b0, 32'd0,        32'd0};
    hand[5]  = '{1'b1, 5'd3, 5'd4, 1'b1, 5'd25, 32'h2005,     1'b1, 1'b1, 1'b0, 5'd0,  32'd0,        1, 1'b0, 32'd0,        32'd0};

    // Reset held across two edges, outputs gated while it is high.
    @(negedge clk);
    #1;
    checkInReset("reset0");
    tick();
    rst = 1'b0;

    for (int i = 0; i < 31; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    // Two writes buffered and a read granted just before reset.
    for (int i = 0; i < 6; i++) runVec(hand[i], $sformatf("hand%0d", i));
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checkInReset("hrst");
    checkOutput("hrst.wbuf_count_before", 32'(wbuf_count), 32'd2);
    checkOutput("hrst.rd_rsp_valid_before", 32'(rd_rsp_valid), 32'd1);
    sampleHold();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) runVec(idleVec, $sformatf("post%0d", i));
    checkOutput("post.r24_unwritten", tbRegs[24], 32'd0);
    checkOutput("post.r25_unwritten", tbRegs[25], 32'd0);

    // Randomized traffic against the queue model; starts from a reset.
    mq.delete();
    mStreak   = 0;
    mRsp      = 1'b0;
    mExpKnown = 1'b0;
    mExpA     = 32'd0;
    mExpB     = 32'd0;
    pending   = 1'b0;
    for (int r = 0; r < 32; r++) begin
      mRegs[r]  = 32'd0;
      mKnown[r] = (r == 0);
    end
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    sampleHold();
    tick();

    for (int n = 0; n < 600; n++) begin
      bit          rdv, wrv, rstV, hz, gW, gR, wOk;
      logic [4:0]  rs, rt, wa;
      logic [31:0] wd;
      string       tag;
      tag  = $sformatf("rnd%0d", n);
      rstV = ($urandom_range(0, 99) < 2);
      if (pending) begin
        rdv = 1'b1;
        rs  = rd_rs;
        rt  = rd_rt;
      end else begin
        rdv = ($urandom_range(0, 99) < 50);
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
      end
      wrv = ($urandom_range(0, 99) < 60);
      wa  = 5'($urandom_range(0, 7));
      wd  = $urandom;
      rst = rstV;
      applyStimulus(rdv, rs, rt, wrv, wa, wd);
      holdCheck(tag);
      #1;
      if (rstV) begin
        checkInReset(tag);
        mq.delete();
        mStreak = 0;
        mRsp    = 1'b0;
        pending = 1'b0;
      end else begin
        hz = 1'b0;
        if (rdv)
          foreach (mq[k])
            if (mq[k].addr != 5'd0 && (mq[k].addr == rs || mq[k].addr == rt)) hz = 1'b1;
        gW  = (mq.size() > 0) && (!rdv || hz || mStreak < MAXB);
        gR  = !gW && rdv;
        wOk = (mq.size() < DEPTH);
        checkOutput({tag, ".rd_req_ready"}, 32'(rd_req_ready), 32'(gR));
        checkOutput({tag, ".wr_req_ready"}, 32'(wr_req_ready), 32'(wOk));
        checkOutput({tag, ".rf_regwrite"},  32'(rf_regwrite),  32'(gW));
        checkOutput({tag, ".rf_rd"},        32'(rf_rd),        gW ? 32'(mq[0].addr) : 32'd0);
        checkOutput({tag, ".rf_writedata"}, rf_writedata,      gW ? mq[0].data : 32'd0);
        checkOutput({tag, ".wbuf_count"},   32'(wbuf_count),   mq.size());
        checkOutput({tag, ".rd_rsp_valid"}, 32'(rd_rsp_valid), 32'(mRsp));
        checkOutput({tag, ".rf_rs"},        32'(rf_rs),        32'(rs));
        if (mRsp && mExpKnown) begin
          checkOutput({tag, ".rdataA"}, rfA, mExpA);
          checkOutput({tag, ".rdataB"}, rfB, mExpB);
        end
        if (gR) begin
          mExpA     = mRegs[rs];
          mExpB     = mRegs[rt];
          mExpKnown = mKnown[rs] && mKnown[rt];
        end
        if (gW) begin
          mRegs[mq[0].addr]  = mq[0].data;
          mKnown[mq[0].addr] = 1'b1;
          void'(mq.pop_front());
          mStreak = rdv ? ((mStreak + 1 > MAXB) ? MAXB : mStreak + 1) : 0;
        end else begin
          mStreak = 0;
        end
        if (wrv && wOk && wa != 5'd0) mq.push_back('{wa, wd});
        mRsp    = gR;
        pending = rdv && !gR;
      end
      sampleHold();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
